// File: rtl/gmii_rx_fl_buf.sv
// GMII receive to FrameLink buffer: strips preamble, packs bytes into words,
// and releases only complete, error-free, length-valid frames.
module gmii_rx_fl_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DREM_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1,
    parameter int FIFO_DEPTH = 512,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1522,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [7:0]            RXD,
    input  logic                  RXDV,
    input  logic                  RXER,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic [DREM_WIDTH-1:0] TX_REM,
    output logic                  TX_SOF_N,
    output logic                  TX_SOP_N,
    output logic                  TX_EOF_N,
    output logic                  TX_EOP_N,
    output logic                  TX_SRC_RDY_N,
    input  logic                  TX_DST_RDY_N,
    output logic [CNT_WIDTH-1:0]  FRAMES_OK,
    output logic [CNT_WIDTH-1:0]  FRAMES_DROP,
    output logic                  FIFO_FULL
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = $clog2(MAX_LEN + 2);
    localparam int EW    = DATA_WIDTH + DREM_WIDTH + 1;

    localparam logic [LW-1:0] MIN_L = LW'(MIN_LEN);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] SAT_L = LW'(MAX_LEN + 1);
    localparam logic [AW:0]   DEPTH_P = {1'b1, {AW{1'b0}}};

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PREAMBLE = 2'd1;
    localparam logic [1:0] DATA     = 2'd2;
    localparam logic [1:0] DROP     = 2'd3;

    logic [1:0]            state, state_nxt;
    logic [LW-1:0]         len, len_nxt;
    logic                  bad, bad_nxt;
    logic [DATA_WIDTH-1:0] pack, pack_nxt;
    logic [DREM_WIDTH-1:0] lane, rem_last;
    logic                  we, fin, good, inc_drop;
    logic [EW-1:0]         wdata, rdata;
    logic [EW-1:0]         mem [FIFO_DEPTH];

    logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
    logic [AW:0] wr_post, wr_ptr_nxt, commit_nxt, rd_addr;
    logic        full, xfer, avail;

    logic                  out_valid, out_sof, out_eof, first;
    logic [DATA_WIDTH-1:0] out_data;
    logic [DREM_WIDTH-1:0] out_rem;
    logic [CNT_WIDTH-1:0]  ok_cnt, drop_cnt;

    assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign lane     = (BYTES == 1) ? '0 : DREM_WIDTH'(len);
    assign rem_last = (BYTES == 1) ? '0 : DREM_WIDTH'(len - LW'(1));

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        bad_nxt   = bad;
        pack_nxt  = pack;
        we        = 1'b0;
        wdata     = {1'b0, {DREM_WIDTH{1'b1}}, pack};
        fin       = 1'b0;
        good      = 1'b0;
        inc_drop  = 1'b0;
        unique case (state)
            IDLE: begin
                len_nxt = '0;
                bad_nxt = 1'b0;
                if (RXDV) begin
                    if (RXD == 8'h55)      state_nxt = PREAMBLE;
                    else if (RXD == 8'hD5) state_nxt = DATA;
                    else                   state_nxt = DROP;
                end
            end
            PREAMBLE: begin
                if (!RXDV)             state_nxt = IDLE;
                else if (RXD == 8'hD5) state_nxt = DATA;
                else if (RXD != 8'h55) state_nxt = DROP;
            end
            DATA: begin
                if (RXDV) begin
                    // a byte landing in lane 0 flushes the previously packed word
                    if (lane == '0) pack_nxt = '0;
                    if (len != '0 && lane == '0) begin
                        if (full) bad_nxt = 1'b1;
                        else      we = 1'b1;
                    end
                    pack_nxt[8*int'(lane) +: 8] = RXD;
                    if (RXER) bad_nxt = 1'b1;
                    if (len != SAT_L) len_nxt = len + LW'(1);
                end else begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                    if (len == '0 || full) begin
                        bad_nxt = 1'b1;
                    end else begin
                        we    = 1'b1;
                        wdata = {1'b1, rem_last, pack};
                    end
                    good     = !bad_nxt && len >= MIN_L && len <= MAX_L;
                    inc_drop = !good;
                end
            end
            DROP: begin
                if (!RXDV) begin
                    state_nxt = IDLE;
                    inc_drop  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_post    = wr_ptr + {{AW{1'b0}}, we};
    assign commit_nxt = (fin && good) ? wr_post : commit_ptr;
    assign wr_ptr_nxt = (fin && !good) ? commit_ptr : wr_post;

    // rd_ptr is the head still owned by the FIFO, including the word on TX
    assign xfer    = out_valid && !TX_DST_RDY_N;
    assign rd_addr = rd_ptr + {{AW{1'b0}}, xfer};
    assign avail   = rd_addr != commit_nxt;
    assign rdata   = (we && wr_ptr == rd_addr) ? wdata : mem[rd_addr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (we) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            len        <= '0;
            bad        <= 1'b0;
            pack       <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_data   <= '0;
            out_rem    <= '1;
            first      <= 1'b1;
            ok_cnt     <= '0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            bad        <= bad_nxt;
            pack       <= pack_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_nxt;
            rd_ptr     <= rd_addr;
            out_valid  <= avail;
            if (xfer) first <= out_eof;
            if (avail) begin
                out_data <= rdata[DATA_WIDTH-1:0];
                out_eof  <= rdata[EW-1];
                out_rem  <= rdata[EW-1] ? rdata[DATA_WIDTH +: DREM_WIDTH] : '1;
                out_sof  <= xfer ? out_eof : first;
            end else begin
                out_sof <= 1'b0;
                out_eof <= 1'b0;
                out_rem <= '1;
            end
            if (fin && good && ok_cnt != '1) ok_cnt <= ok_cnt + CNT_WIDTH'(1);
            if (inc_drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
        end
    end

    assign TX_DATA      = out_data;
    assign TX_REM       = out_rem;
    assign TX_SOF_N     = !out_sof;
    assign TX_SOP_N     = !out_sof;
    assign TX_EOF_N     = !out_eof;
    assign TX_EOP_N     = !out_eof;
    assign TX_SRC_RDY_N = !out_valid;
    assign FRAMES_OK    = ok_cnt;
    assign FRAMES_DROP  = drop_cnt;
    assign FIFO_FULL    = full;

endmodule

// File: doc/gmii_rx_fl_buf.md
Name: gmii_rx_fl_buf

Overview:
- Receive-side GMII-to-FrameLink buffer; parametrised single-clock successor of the GMII IBUF.
- Strips preamble/SFD from the GMII byte stream and packs bytes into DATA_WIDTH words.
- Stores each frame speculatively in a commit/rollback FIFO, so only complete, error-free, length-valid frames appear on the FrameLink TX side.
- Dropped frames leave no trace in the FIFO; OK and dropped frames are counted.

Parameters:
- DATA_WIDTH, 32, FrameLink data width in bits; legal values 8/16/32/64.
- DREM_WIDTH, log2(DATA_WIDTH/8) (min 1), DREM width.
- FIFO_DEPTH, 512, FIFO depth in words; power of 2, at least 16.
- MIN_LEN, 64, minimum accepted frame length in bytes after SFD, FCS included.
- MAX_LEN, 1522, maximum accepted frame length in bytes.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- CLK  in  1  single clock; GMII RX and FrameLink share it.
- RESET  in  1  asynchronous, active-low reset.
- RXD  in  8  GMII receive data.
- RXDV  in  1  GMII receive data valid.
- RXER  in  1  GMII receive error.
- TX_DATA  out  DATA_WIDTH  FrameLink data; first byte in bits [7:0].
- TX_REM  out  DREM_WIDTH  valid bytes minus 1; meaningful only on EOF.
- TX_SOF_N, TX_SOP_N  out  1  start of frame/part; the two are identical.
- TX_EOF_N, TX_EOP_N  out  1  end of frame/part; the two are identical.
- TX_SRC_RDY_N  out  1  word valid.
- TX_DST_RDY_N  in  1  sink ready.
- FRAMES_OK  out  CNT_WIDTH  committed frame count.
- FRAMES_DROP  out  CNT_WIDTH  dropped frame count.
- FIFO_FULL  out  1  FIFO full flag.

Behaviour:
- Reset values (asserted, async):
  - FSM goes to IDLE; all pointers and counters are 0.
  - TX_SRC_RDY_N, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N = 1.
  - TX_DATA = 0, TX_REM = all ones, FIFO_FULL = 0.
  - An in-flight or buffered frame is discarded and not counted.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - RXDV=1 with RXD=0x55 -> PREAMBLE.
  - RXDV=1 with RXD=0xD5 -> DATA.
  - RXDV=1 with any other byte -> DROP.
- PREAMBLE:
  - 0x55 stays in PREAMBLE.
  - 0xD5 -> DATA.
  - Any other byte -> DROP.
  - RXDV=0 -> IDLE; nothing counted.
- DATA, per byte with RXDV=1:
  - Byte goes into the pack register at lane (len mod DATA_WIDTH/8), little-endian; len increments, saturating at MAX_LEN+1.
  - When the pack register is full and the next byte arrives, the full word is written with EOF=0.
  - A write while FIFO full, or RXER=1, sets the bad flag; no write happens while full.
- DATA, on the first cycle with RXDV=0 (end of frame):
  - If len=0, the frame is bad and nothing is written.
  - Otherwise the pending word is written with EOF=1 and REM=(len-1) mod (DATA_WIDTH/8), unless the FIFO is full, in which case the frame is bad.
  - Good frame = not bad and MIN_LEN <= len <= MAX_LEN.
  - Good frame: commit_ptr takes the post-write wr_ptr and FRAMES_OK increments.
  - Bad frame: wr_ptr returns to commit_ptr and FRAMES_DROP increments.
  - FSM -> IDLE in the same cycle.
- DROP: waits for RXDV=0, then FRAMES_DROP increments and FSM -> IDLE.
- FIFO:
  - Each entry is {EOF, REM, DATA}.
  - Pointers carry one extra wrap bit.
  - FIFO_FULL = (wr_ptr - rd_ptr == FIFO_DEPTH).
  - The read side sees only entries below commit_ptr.
- TX side:
  - First-word-fall-through, registered output.
  - Frame committed in cycle T -> TX_SRC_RDY_N=0 in cycle T+1.
  - A transfer occurs when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0; with the sink always ready, throughput is 1 word/cycle.
  - Outputs hold stable while TX_DST_RDY_N=1.
  - TX_SOF_N=0 on the first word after reset and on the first word after an EOF word.
  - TX_EOF_N follows the stored EOF bit; TX_REM = all ones when not EOF.
- Simultaneous events:
  - Commit and read in the same cycle both take effect.
  - Rollback never moves below rd_ptr, because commit_ptr >= rd_ptr always holds.
- Counters saturate at all ones.

Test Plan:
- 7x0x55, 0xD5, then 64 bytes 0x00..0x3F, DATA_WIDTH=32 -> 16 words: first word 0x03020100 with SOF; last word 0x3F3E3D3C with EOF, REM=3; FRAMES_OK=1.
- 65-byte frame -> 17 words, last word REM=0, data 0x40 in [7:0]; a 63-byte frame -> no TX activity, FRAMES_DROP=1.
- RXER=1 on byte 30 of a 100-byte frame, followed by a good 64-byte frame -> only the second frame output; FRAMES_DROP=1, FRAMES_OK=1.
- FIFO_DEPTH=16, TX_DST_RDY_N=1, two 64-byte frames -> first commits with FIFO_FULL=1, second dropped; releasing DST_RDY yields exactly 16 words.
- TX_DST_RDY_N toggled every other cycle over 3 back-to-back frames (IPG 12) -> data and SOF/EOF identical to an always-ready run.
- RESET pulled low mid-frame and mid-readout -> TX_SRC_RDY_N=1 immediately; counters 0; the next good frame is output normally.
